// File: rtl/fpu_pkg.sv
// Shared float-side definitions: OP-FP encodings, op enum, FCLASS bit positions and helpers.
package fpu_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] F7_FCVT_W    = 7'b1100000;
    localparam logic [6:0] F7_FMV_CLASS = 7'b1110000;
    localparam logic [6:0] F7_FCMP      = 7'b1010000;
    localparam logic [2:0] F3_FMV   = 3'b000;
    localparam logic [2:0] F3_CLASS = 3'b001;
    localparam logic [2:0] F3_FEQ   = 3'b010;
    localparam logic [2:0] F3_FLT   = 3'b001;
    localparam logic [2:0] F3_FLE   = 3'b000;

    typedef enum logic [2:0] {
        OP_NONE, OP_CVTW, OP_CVTWU, OP_FMV, OP_CLASS, OP_FEQ, OP_FLT, OP_FLE
    } op_e;

    localparam int CLS_NINF  = 0;
    localparam int CLS_NNORM = 1;
    localparam int CLS_NSUB  = 2;
    localparam int CLS_NZERO = 3;
    localparam int CLS_PZERO = 4;
    localparam int CLS_PSUB  = 5;
    localparam int CLS_PNORM = 6;
    localparam int CLS_PINF  = 7;
    localparam int CLS_SNAN  = 8;
    localparam int CLS_QNAN  = 9;

    function automatic logic [9:0] fclass(input logic [31:0] f);
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MANT_W-1:0] m;
        s = f[31];
        e = f[30:23];
        m = f[22:0];
        fclass = '0;
        if (e == '1) begin
            if (m == '0) fclass[s ? CLS_NINF : CLS_PINF] = 1'b1;
            else         fclass[m[22] ? CLS_QNAN : CLS_SNAN] = 1'b1;
        end else if (e == '0) begin
            if (m == '0) fclass[s ? CLS_NZERO : CLS_PZERO] = 1'b1;
            else         fclass[s ? CLS_NSUB : CLS_PSUB] = 1'b1;
        end else begin
            fclass[s ? CLS_NNORM : CLS_PNORM] = 1'b1;
        end
    endfunction

    function automatic op_e decode(input logic [31:0] inst);
        logic [2:0] f3;
        logic [4:0] rs2;
        f3 = inst[14:12];
        rs2 = inst[24:20];
        decode = OP_NONE;
        if (inst[6:0] == OPC_OP_FP) begin
            case (inst[31:25])
                F7_FCVT_W: begin
                    if (rs2 == 5'd0)      decode = OP_CVTW;
                    else if (rs2 == 5'd1) decode = OP_CVTWU;
                end
                F7_FMV_CLASS: begin
                    if (f3 == F3_FMV)        decode = OP_FMV;
                    else if (f3 == F3_CLASS) decode = OP_CLASS;
                end
                F7_FCMP: begin
                    if (f3 == F3_FEQ)      decode = OP_FEQ;
                    else if (f3 == F3_FLT) decode = OP_FLT;
                    else if (f3 == F3_FLE) decode = OP_FLE;
                end
                default: decode = OP_NONE;
            endcase
        end
    endfunction
endpackage

// File: rtl/fp_to_int_cvt.sv
// binary32 -> 32-bit integer, round toward zero. Align shift happens before the
// internal register, saturation and negation after it.
module fp_to_int_cvt
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              is_unsigned,
    input  logic              sign,
    input  logic [EXP_W-1:0]  expo,
    input  logic [MANT_W-1:0] mant,
    output logic [31:0]       res,
    output logic              nv
);
    logic        sign_q, sign_d, uns_q, uns_d, nan_q, nan_d, big_q, big_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  ue;
    logic [54:0] sh;

    always_comb begin
        sign_d = sign;
        uns_d  = is_unsigned;
        nan_d  = (expo == '1) && (mant != '0);
        // exponent >= 32 means |x| >= 2^32: out of range for both W and WU
        big_d  = expo >= 8'(BIAS + 32);
        ue     = expo - 8'(BIAS);
        sh     = {31'd0, 1'b1, mant} << ue[4:0];
        mag_d  = (expo < 8'(BIAS)) ? 32'd0 : 32'(sh >> MANT_W);

        res = mag_q;
        nv  = 1'b0;
        if (uns_q) begin
            if (nan_q || (!sign_q && big_q)) begin
                res = '1;
                nv  = 1'b1;
            end else if (sign_q) begin
                res = '0;
                nv  = big_q || (mag_q != '0);
            end
        end else begin
            if (nan_q || (!sign_q && (big_q || mag_q[31]))) begin
                res = 32'h7fff_ffff;
                nv  = 1'b1;
            end else if (sign_q) begin
                if (big_q || mag_q > 32'h8000_0000) begin
                    res = 32'h8000_0000;
                    nv  = 1'b1;
                end else begin
                    res = -mag_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            uns_q  <= 1'b0;
            nan_q  <= 1'b0;
            big_q  <= 1'b0;
            mag_q  <= '0;
        end else if (en) begin
            sign_q <= sign_d;
            uns_q  <= uns_d;
            nan_q  <= nan_d;
            big_q  <= big_d;
            mag_q  <= mag_d;
        end
    end
endmodule

// File: rtl/fpu_int_writeback.sv
// Float ops with an integer destination: 3-stage pipe (decode/classify, compare/align,
// saturate/output) under a single global stall.
module fpu_int_writeback
    import fpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int FLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [FLEN-1:0] opa,
    input  logic [FLEN-1:0] opb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_nv,
    output logic            busy
);
    logic            adv;
    logic [2:0]      vld_q, vld_d;
    op_e             op1_q, op1_d, op2_q, op2_d;
    logic [4:0]      rd1_q, rd1_d, rd2_q, rd2_d, out_rd_q, out_rd_d;
    logic [FLEN-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [9:0]      cls_a1_q, cls_a1_d;
    logic            b_nan1_q, b_nan1_d, b_snan1_q, b_snan1_d;
    logic [XLEN-1:0] data2_q, data2_d, out_data_q, out_data_d;
    logic            nv2_q, nv2_d, out_nv_q, out_nv_d;
    logic [XLEN-1:0] cvt_res;
    logic            cvt_nv, is_cvt2;
    logic            a_nan, a_snan, any_nan, any_snan, both_zero, feq, flt;
    logic            unused_rs1;

    assign unused_rs1 = ^inst[19:15];
    assign adv       = !vld_q[2] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[2];
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign out_nv    = out_nv_q;
    assign busy      = |vld_q;

    fp_to_int_cvt u_cvt (
        .clk         (clk),
        .rst         (rst),
        .en          (adv),
        .is_unsigned (op1_q == OP_CVTWU),
        .sign        (a1_q[31]),
        .expo        (a1_q[30:23]),
        .mant        (a1_q[22:0]),
        .res         (cvt_res),
        .nv          (cvt_nv)
    );

    always_comb begin
        // S1: decode and classify; unknown encodings are swallowed here
        op1_d     = decode(inst);
        vld_d[0]  = in_valid && (op1_d != OP_NONE);
        rd1_d     = inst[11:7];
        a1_d      = opa;
        b1_d      = opb;
        cls_a1_d  = fclass(opa);
        b_nan1_d  = (opb[30:23] == '1) && (opb[22:0] != '0);
        b_snan1_d = b_nan1_d && !opb[22];

        // S2: compares, FMV, FCLASS
        a_nan     = cls_a1_q[CLS_SNAN] || cls_a1_q[CLS_QNAN];
        a_snan    = cls_a1_q[CLS_SNAN];
        any_nan   = a_nan || b_nan1_q;
        any_snan  = a_snan || b_snan1_q;
        both_zero = (a1_q[30:0] == '0) && (b1_q[30:0] == '0);
        feq       = !any_nan && ((a1_q == b1_q) || both_zero);
        if (any_nan || both_zero)   flt = 1'b0;
        else if (a1_q[31] != b1_q[31]) flt = a1_q[31];
        else if (!a1_q[31])         flt = a1_q[30:0] < b1_q[30:0];
        else                        flt = a1_q[30:0] > b1_q[30:0];

        vld_d[1] = vld_q[0];
        op2_d    = op1_q;
        rd2_d    = rd1_q;
        data2_d  = '0;
        nv2_d    = 1'b0;
        case (op1_q)
            OP_FMV:   data2_d = a1_q;
            OP_CLASS: data2_d = XLEN'(cls_a1_q);
            OP_FEQ: begin
                data2_d = XLEN'(feq);
                nv2_d   = any_snan;
            end
            OP_FLT: begin
                data2_d = XLEN'(flt);
                nv2_d   = any_nan;
            end
            OP_FLE: begin
                data2_d = XLEN'(flt || feq);
                nv2_d   = any_nan;
            end
            default: ;
        endcase

        // S3: select conversion result or the S2 result into the output regs
        is_cvt2    = (op2_q == OP_CVTW) || (op2_q == OP_CVTWU);
        vld_d[2]   = vld_q[1];
        out_rd_d   = rd2_q;
        out_data_d = is_cvt2 ? cvt_res : data2_q;
        out_nv_d   = is_cvt2 ? cvt_nv : nv2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            op1_q      <= OP_NONE;
            op2_q      <= OP_NONE;
            rd1_q      <= '0;
            rd2_q      <= '0;
            a1_q       <= '0;
            b1_q       <= '0;
            cls_a1_q   <= '0;
            b_nan1_q   <= 1'b0;
            b_snan1_q  <= 1'b0;
            data2_q    <= '0;
            nv2_q      <= 1'b0;
            out_rd_q   <= '0;
            out_data_q <= '0;
            out_nv_q   <= 1'b0;
        end else if (adv) begin
            vld_q      <= vld_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            cls_a1_q   <= cls_a1_d;
            b_nan1_q   <= b_nan1_d;
            b_snan1_q  <= b_snan1_d;
            data2_q    <= data2_d;
            nv2_q      <= nv2_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
            out_nv_q   <= out_nv_d;
        end
    end
endmodule
